fir_mac_sched: RTL and testbench

FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_mac_unit.sv | 21 ++
 rtl/fir_mac_sched.sv | 106 ++++++++++
 tb/tb_fir_mac_sched.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state, default coefficient table and accumulator width
// for the FIR MAC scheduler.
package fir_pkg;
   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
   function automatic int acc_w(input int w);
      return 2 * w + 4;
   endfunction
   // Symmetric low-pass defaults for the 9-tap (ORDER=8) filter; extra taps are zero.
   function automatic logic signed [7:0] def_coef(input int k);
      case (k)
         0, 8: return -8'sd12;
         1, 7: return -8'sd26;
         2, 6: return 8'sd14;
         3, 5: return 8'sd89;
         4: return 8'sd127;
         default: return 8'sd0;
      endcase
   endfunction
endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: signed multiply-accumulate with synchronous clear and enable.
module fir_mac_unit #(
   parameter int W = 8,
   parameter int ACC_W = 20
) (
   input logic clock,
   input logic reset,
   input logic clear,
   input logic en,
   input logic signed [W-1:0] a,
   input logic signed [W-1:0] b,
   output logic signed [ACC_W-1:0] acc,
   output logic signed [ACC_W-1:0] sum
);
   logic signed [2*W-1:0] prod;
   assign prod = a * b;
   assign sum = acc + ACC_W'(prod);
   always_ff @(posedge clock)
      if (reset || clear) acc <= '0;
      else if (en) acc <= sum;
endmodule

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: sequential FIR filter, one MAC per cycle over ORDER+1 taps.
// Define FIR_COEF_WR_EN for a writable coefficient file; otherwise coefficients are constant.
module fir_mac_sched
   import fir_pkg::*;
#(
   parameter int ORDER = 8,
   parameter int WIDTH_IN = 8,
   parameter int ACC_W = acc_w(WIDTH_IN)
) (
   input logic clock,
   input logic reset,
   input logic signed [WIDTH_IN-1:0] in_data,
   input logic in_valid,
   output logic in_ready,
   output logic signed [ACC_W-1:0] out_data,
   output logic out_valid,
   input logic out_ready,
   input logic coef_we,
   input logic [3:0] coef_addr,
   input logic signed [WIDTH_IN-1:0] coef_data,
   output logic coef_err,
   output logic busy
);
   localparam int IW = $clog2(ORDER + 1);
   localparam logic [IW-1:0] LAST = IW'(ORDER);
   state_t state;
   logic [IW-1:0] idx;
   logic [ORDER:0][WIDTH_IN-1:0] tap, mac_coef, def_pack;
   logic signed [ACC_W-1:0] acc, sum;
   logic accept;
   assign accept = state == IDLE && in_valid;
   for (genvar k = 0; k <= ORDER; k++) begin : g_def
      assign def_pack[k] = WIDTH_IN'(def_coef(k));
   end
`ifdef FIR_COEF_WR_EN
   localparam logic [3:0] MAX_ADDR = 4'(ORDER);
   logic [ORDER:0][WIDTH_IN-1:0] coef;
   logic wr_ok;
   assign wr_ok = coef_we && state == IDLE && coef_addr <= MAX_ADDR;
   // The MAC reads a snapshot taken at accept, so a same-edge write only affects later samples.
   always_ff @(posedge clock) begin
      if (reset) begin
         coef <= def_pack;
         mac_coef <= def_pack;
         coef_err <= 1'b0;
      end else begin
         coef_err <= coef_we && !wr_ok;
         if (wr_ok) coef[coef_addr] <= coef_data;
         if (accept) mac_coef <= coef;
      end
   end
`else
   logic unused_coef;
   assign unused_coef = ^{coef_we, coef_addr, coef_data};
   assign mac_coef = def_pack;
   assign coef_err = 1'b0;
`endif
   fir_mac_unit #(.W(WIDTH_IN), .ACC_W(ACC_W)) u_mac (
      .clock(clock),
      .reset(reset),
      .clear(accept),
      .en(state == MAC),
      .a(mac_coef[idx]),
      .b(tap[idx]),
      .acc(acc),
      .sum(sum)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         idx <= '0;
         tap <= '0;
         in_ready <= 1'b1;
         busy <= 1'b0;
         out_valid <= 1'b0;
         out_data <= '0;
      end else begin
         case (state)
            IDLE:
               if (in_valid) begin
                  tap <= {tap[ORDER-1:0], in_data};
                  idx <= '0;
                  state <= MAC;
                  in_ready <= 1'b0;
                  busy <= 1'b1;
               end
            MAC: begin
               idx <= idx + 1'b1;
               if (idx == LAST) begin
                  state <= DONE;
                  out_valid <= 1'b1;
                  out_data <= sum;
               end
            end
            DONE:
               if (out_ready) begin
                  state <= IDLE;
                  out_valid <= 1'b0;
                  in_ready <= 1'b1;
                  busy <= 1'b0;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_mac_sched.sv
// tb_fir_mac_sched: table vectors, corner sequences and random samples against
// a convolution model of the 9-tap filter.
module tb_fir_mac_sched;
`ifdef FIR_COEF_WR_EN
   localparam bit WR = 1'b1;
`else
   localparam bit WR = 1'b0;
`endif
   logic clock = 1'b0, reset = 1'b0;
   logic signed [7:0] in_data = '0, coef_data = '0;
   logic in_valid = 1'b0, out_ready = 1'b1, coef_we = 1'b0;
   logic [3:0] coef_addr = '0;
   logic signed [19:0] out_data;
   logic in_ready, out_valid, coef_err, busy;
   int n_tests = 0, n_fail = 0;
   int mc[9];
   int hist[9];

   fir_mac_sched dut (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {int s; int stall; int exp;} vec_t;
   vec_t tbl[18];

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic model_reset();
      mc = '{-12, -26, 14, 89, 127, 89, 14, -26, -12};
      hist = '{default: 0};
   endtask

   task automatic model_push(input int s, output int e);
      for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = s;
      e = 0;
      for (int k = 0; k < 9; k++) e += mc[k] * hist[k];
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
   endtask

   // Sends one sample (plus any coefficient write already on the bus) and checks timing and result.
   task automatic send(input int s, input int stall, output int got);
      int e, lat, low, held;
      bit wr_ok;
      lat = 0;
      while (!in_ready && lat < 40) begin @(posedge clock); #1; lat++; end
      check("in_ready_before_accept", int'(in_ready), 1);
      model_push(s, e);
      wr_ok = WR && coef_we && coef_addr <= 4'd8;
      in_data = 8'(s); in_valid = 1'b1; out_ready = (stall == 0);
      @(posedge clock); #1;
      in_valid = 1'b0;
      if (wr_ok) mc[coef_addr] = int'(coef_data);
      coef_we = 1'b0;
      lat = 0; low = 0;
      while (!out_valid && lat < 30) begin low += int'(!in_ready); @(posedge clock); #1; lat++; end
      check("latency", lat, 9);
      got = int'(out_data);
      check("result_vs_model", got, e);
      for (int i = 0; i < stall; i++) begin
         low += int'(!in_ready);
         held = int'(out_valid);
         check("stall_valid_held", held, 1);
         check("stall_data_stable", int'(out_data), got);
         @(posedge clock); #1;
      end
      low += int'(!in_ready);
      check("in_ready_low_cycles", low, 10 + stall);
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("idle_in_ready", int'(in_ready), 1);
      check("idle_out_valid", int'(out_valid), 0);
   endtask

   task automatic coef_write(input int a, input int d);
      coef_we = 1'b1; coef_addr = 4'(a); coef_data = 8'(d);
      @(posedge clock); #1;
      coef_we = 1'b0;
      check("coef_err_pulse", int'(coef_err), int'(WR && a > 8));
      if (WR && a <= 8) mc[a] = d;
      @(posedge clock); #1;
      check("coef_err_clear", int'(coef_err), 0);
   endtask

   initial begin
      int got, e, lat, seen;
      tbl = '{
         '{1, 0, -12}, '{0, 0, -26}, '{0, 0, 14}, '{0, 0, 89}, '{0, 0, 127},
         '{0, 0, 89}, '{0, 0, 14}, '{0, 0, -26}, '{0, 0, -12},
         '{1, 0, -12}, '{1, 0, -38}, '{1, 0, -24}, '{1, 0, 65}, '{1, 5, 192},
         '{1, 0, 281}, '{1, 0, 295}, '{1, 0, 269}, '{1, 0, 257}};
      model_reset();
      @(posedge clock); #1;
      do_reset();
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_coef_err", int'(coef_err), 0);

      foreach (tbl[i]) begin
         send(tbl[i].s, tbl[i].stall, got);
         check($sformatf("table_%0d", i), got, tbl[i].exp);
      end

      // Reset while the MAC is at idx=4 discards the partial result.
      in_data = 8'sd5; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      check("mid_busy", int'(busy), 1);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_out_data", int'(out_data), 0);
      check("mid_rst_in_ready", int'(in_ready), 1);
      check("mid_rst_busy", int'(busy), 0);
      seen = 0;
      repeat (12) begin @(posedge clock); #1; seen += int'(out_valid); end
      check("mid_rst_no_valid", seen, 0);
      send(1, 0, got);
      check("post_rst_impulse", got, -12);

      repeat (20) begin
         send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 2)), got);
      end

      // Coefficient write port.
      do_reset();
      coef_write(0, 64);
      send(1, 0, got);
      check("wr_impulse", got, WR ? 64 : -12);
      coef_write(12, 33);
      in_data = 8'sd3; in_valid = 1'b1;
      model_push(3, e);
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      coef_we = 1'b1; coef_addr = 4'd1; coef_data = 8'sd5;
      @(posedge clock); #1;
      coef_we = 1'b0;
      check("mac_wr_err", int'(coef_err), int'(WR));
      @(posedge clock); #1;
      check("mac_wr_err_clear", int'(coef_err), 0);
      lat = 0;
      while (!out_valid && lat < 30) begin @(posedge clock); #1; lat++; end
      check("mac_wr_valid", int'(out_valid), 1);
      check("mac_wr_result", int'(out_data), e);
      @(posedge clock); #1;
      coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'sd10;
      send(2, 0, got);
      for (int i = 0; i < 3; i++) send(i - 1, 0, got);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
